// File: rtl/asi_pkg.sv
// Shared definitions for the asi slave: bus widths, arbiter state encoding
// and the byte-address to word-index helper.
package asi_pkg;

  localparam int AXI_AW      = 32;
  localparam int AXI_DW      = 32;
  localparam int SLV_BYTEW   = AXI_DW / 8;
  localparam int SLV_BYTE_SH = $clog2(SLV_BYTEW);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_state_t;

  // Full-width word index so out-of-range checks see every address bit.
  function automatic logic [AXI_AW-1:0] addr_to_word(input logic [AXI_AW-1:0] addr);
    return addr >> SLV_BYTE_SH;
  endfunction

endpackage

// File: rtl/asi_mem_arb_if.sv
// Bundle between the asi read/write user ports, the SRAM macro and the
// burst arbiter; slave is the arbiter view, master is the surrounding logic.
interface asi_mem_arb_if #(
  parameter int MEM_AW = 10
);
  import asi_pkg::*;

  // Handshake: a side raises req and holds it; while gnt is high it may
  // issue one beat per cycle (re/we), with no backpressure, and the grant
  // is kept until the beat flagged last has been issued.
  logic                 r_req;
  logic                 r_gnt;
  logic                 r_re;
  logic [AXI_AW-1:0]    r_addr;
  logic                 r_last;
  logic [AXI_DW-1:0]    r_rdata;
  logic                 r_rvalid;
  logic                 r_rslverr;

  logic                 w_req;
  logic                 w_gnt;
  logic                 w_we;
  logic [AXI_AW-1:0]    w_addr;
  logic [AXI_DW-1:0]    w_wdata;
  logic [SLV_BYTEW-1:0] w_be;
  logic                 w_last;
  logic                 w_slverr;

  logic                 mem_en;
  logic                 mem_we;
  logic [MEM_AW-1:0]    mem_addr;
  logic [AXI_DW-1:0]    mem_wdata;
  logic [SLV_BYTEW-1:0] mem_be;
  logic [AXI_DW-1:0]    mem_rdata;

  logic                 arb_err;
  arb_state_t           arb_state;

  modport slave (
    input  r_req, r_re, r_addr, r_last,
    input  w_req, w_we, w_addr, w_wdata, w_be, w_last,
    input  mem_rdata,
    output r_gnt, r_rdata, r_rvalid, r_rslverr,
    output w_gnt, w_slverr,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output arb_err, arb_state
  );

  modport master (
    output r_req, r_re, r_addr, r_last,
    output w_req, w_we, w_addr, w_wdata, w_be, w_last,
    output mem_rdata,
    input  r_gnt, r_rdata, r_rvalid, r_rslverr,
    input  w_gnt, w_slverr,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  arb_err, arb_state
  );

endinterface

// File: rtl/asi_ws_pipe.sv
// Fixed-depth shift register used to line up side-band bits with a
// memory's wait-state latency.
module asi_ws_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/asi_mem_arb.sv
// Burst arbiter sharing one single-port SRAM between the asi read and write
// paths, with range checking and wait-state aligned read return.
module asi_mem_arb
  import asi_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int MEM_WS    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  asi_mem_arb_if.slave bus
);

  localparam int MEM_AW = $clog2(MEM_WORDS);

  arb_state_t        st;
  arb_state_t        st_nxt;
  logic              last_wr;
  logic              last_wr_nxt;

  logic [AXI_AW-1:0] r_word;
  logic [AXI_AW-1:0] w_word;
  logic              r_in;
  logic              w_in;
  logic              rd_acc;
  logic              wr_acc;
  logic              stray;
  logic [1:0]        ret_q;
  logic              w_slverr_q;
  logic              arb_err_q;

  assign r_word = addr_to_word(bus.r_addr);
  assign w_word = addr_to_word(bus.w_addr);
  assign r_in   = r_word < AXI_AW'(MEM_WORDS);
  assign w_in   = w_word < AXI_AW'(MEM_WORDS);

  assign rd_acc = (st == ARB_RD) && bus.r_re;
  assign wr_acc = (st == ARB_WR) && bus.w_we;
  assign stray  = (bus.r_re && (st != ARB_RD)) || (bus.w_we && (st != ARB_WR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ARB_IDLE;
      last_wr <= 1'b1;
    end else begin
      st      <= st_nxt;
      last_wr <= last_wr_nxt;
    end
  end

  // Contention goes to whichever side did not own the previous burst.
  always_comb begin
    st_nxt      = st;
    last_wr_nxt = last_wr;
    unique case (st)
      ARB_IDLE: begin
        if (bus.r_req && (!bus.w_req || last_wr)) begin
          st_nxt      = ARB_RD;
          last_wr_nxt = 1'b0;
        end else if (bus.w_req) begin
          st_nxt      = ARB_WR;
          last_wr_nxt = 1'b1;
        end
      end
      ARB_RD: if (bus.r_re && bus.r_last) st_nxt = ARB_IDLE;
      ARB_WR: if (bus.w_we && bus.w_last) st_nxt = ARB_IDLE;
      default: st_nxt = ARB_IDLE;
    endcase
  end

  assign bus.r_gnt     = (st == ARB_RD);
  assign bus.w_gnt     = (st == ARB_WR);
  assign bus.arb_state = st;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = r_word[MEM_AW-1:0];
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (st == ARB_WR) bus.mem_addr = w_word[MEM_AW-1:0];
    if (rd_acc && r_in) bus.mem_en = 1'b1;
    if (wr_acc && w_in) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = bus.w_wdata;
      bus.mem_be    = bus.w_be;
    end
  end

  // Error beats ride the same pipe as good beats so return order holds.
  asi_ws_pipe #(
    .DEPTH (MEM_WS),
    .W     (2)
  ) u_ws_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({rd_acc, rd_acc && !r_in}),
    .q     (ret_q)
  );

  assign bus.r_rvalid  = ret_q[1];
  assign bus.r_rslverr = ret_q[1] && ret_q[0];
  assign bus.r_rdata   = (ret_q[1] && !ret_q[0]) ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_slverr_q <= 1'b0;
      arb_err_q  <= 1'b0;
    end else begin
      w_slverr_q <= wr_acc && !w_in;
      arb_err_q  <= arb_err_q || stray;
    end
  end

  assign bus.w_slverr = w_slverr_q;
  assign bus.arb_err  = arb_err_q;

endmodule

// File: tb/tb_asi_mem_arb.sv
// Bench for asi_mem_arb: SRAM model, burst drivers, read/write-error
// scoreboard and a random burst mix against a shadow memory.
module tb_asi_mem_arb;
  import asi_pkg::*;

  localparam int MEM_WORDS = 64;
  localparam int MEM_WS    = 2;
  localparam int MEM_AW    = $clog2(MEM_WORDS);
  localparam int BOUND     = 40;
  localparam int EW        = 32 + 1 + AXI_DW;

  typedef logic [31:0]          arr8_t [8];
  typedef logic [SLV_BYTEW-1:0] be8_t  [8];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic model_last_wr = 1'b1;

  logic [EW-1:0]     exp_q [$];
  int                werr_q [$];
  logic [AXI_DW-1:0] ref_mem [MEM_WORDS];
  logic [AXI_DW-1:0] sram [MEM_WORDS];
  logic [AXI_DW-1:0] sram_pipe [MEM_WS];

  asi_mem_arb_if #(.MEM_AW(MEM_AW)) bus ();

  asi_mem_arb #(
    .MEM_WORDS (MEM_WORDS),
    .MEM_WS    (MEM_WS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // single-port SRAM model with MEM_WS read latency
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we)
      for (int b = 0; b < SLV_BYTEW; b++)
        if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    sram_pipe[0] <= (bus.mem_en && !bus.mem_we) ? sram[bus.mem_addr] : '0;
    for (int i = 1; i < MEM_WS; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign bus.mem_rdata = sram_pipe[MEM_WS-1];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    logic          exp_w;
    if (rst_n) begin
      if (bus.r_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_due_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
          chk("rd_slverr", bus.r_rslverr, e[AXI_DW]);
          chk("rd_data", bus.r_rdata, e[AXI_DW-1:0]);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
        e = exp_q.pop_front();
        chk("rd_missing", 0, 1);
      end
      exp_w = (werr_q.size() > 0) && (werr_q[0] == cyc);
      if (exp_w) void'(werr_q.pop_front());
      if (bus.w_slverr || exp_w) chk("w_slverr", bus.w_slverr, exp_w);
    end
  end

  task automatic clear_inputs();
    bus.r_req = 0; bus.r_re = 0; bus.r_addr = '0; bus.r_last = 0;
    bus.w_req = 0; bus.w_we = 0; bus.w_addr = '0; bus.w_wdata = '0;
    bus.w_be = '0; bus.w_last = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    exp_q.delete();
    werr_q.delete();
    model_last_wr = 1;
    clear_inputs();
    #1;
    chk("rst_r_gnt", bus.r_gnt, 0);
    chk("rst_w_gnt", bus.w_gnt, 0);
    chk("rst_r_rvalid", bus.r_rvalid, 0);
    chk("rst_r_rslverr", bus.r_rslverr, 0);
    chk("rst_w_slverr", bus.w_slverr, 0);
    chk("rst_arb_err", bus.arb_err, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_state", bus.arb_state, ARB_IDLE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic rd_burst(input int n, input arr8_t a, input int exp_wait,
                          input bit stray, input int rst_at);
    int k;
    logic [31:0] w;
    logic in_r;
    bus.r_req = 1;
    k = 0;
    while (!bus.r_gnt && k < BOUND) begin @(posedge clk); #1; k++; end
    chk("r_gnt_wait", k, exp_wait);
    if (!bus.r_gnt) begin bus.r_req = 0; return; end
    model_last_wr = 0;
    for (int i = 0; i < n; i++) begin
      bus.r_re = 1; bus.r_addr = a[i]; bus.r_last = (i == n-1);
      if (stray && i == 0) begin
        bus.w_we = 1; bus.w_addr = a[0]; bus.w_wdata = $urandom; bus.w_be = '1;
      end
      w = a[i] / SLV_BYTEW;
      in_r = w < MEM_WORDS;
      #1;
      chk("rd_mem_en", bus.mem_en, in_r);
      chk("rd_mem_we", bus.mem_we, 0);
      if (in_r) chk("rd_mem_addr", bus.mem_addr, w[MEM_AW-1:0]);
      if (i == rst_at) begin
        rst_n = 0;
        #1;
        chk("rst_mid_mem_en", bus.mem_en, 0);
        do_reset();
        return;
      end
      exp_q.push_back({32'(cyc + MEM_WS), !in_r, in_r ? ref_mem[w[MEM_AW-1:0]] : {AXI_DW{1'b0}}});
      @(posedge clk); #1;
      if (stray && i == 0) begin
        bus.w_we = 0;
        chk("arb_err_set", bus.arb_err, 1);
      end
    end
    bus.r_re = 0; bus.r_last = 0; bus.r_req = 0;
  endtask

  task automatic wr_burst(input int n, input arr8_t a, input arr8_t d,
                          input be8_t be, input int exp_wait);
    int k;
    logic [31:0] w;
    logic in_r;
    bus.w_req = 1;
    k = 0;
    while (!bus.w_gnt && k < BOUND) begin @(posedge clk); #1; k++; end
    chk("w_gnt_wait", k, exp_wait);
    if (!bus.w_gnt) begin bus.w_req = 0; return; end
    model_last_wr = 1;
    for (int i = 0; i < n; i++) begin
      bus.w_we = 1; bus.w_addr = a[i]; bus.w_wdata = d[i]; bus.w_be = be[i];
      bus.w_last = (i == n-1);
      w = a[i] / SLV_BYTEW;
      in_r = w < MEM_WORDS;
      #1;
      chk("wr_mem_en", bus.mem_en, in_r);
      chk("wr_mem_we", bus.mem_we, in_r);
      if (in_r) begin
        chk("wr_mem_addr", bus.mem_addr, w[MEM_AW-1:0]);
        chk("wr_mem_be", bus.mem_be, be[i]);
        chk("wr_mem_wdata", bus.mem_wdata, d[i]);
        for (int b = 0; b < SLV_BYTEW; b++)
          if (be[i][b]) ref_mem[w[MEM_AW-1:0]][8*b +: 8] = d[i][8*b +: 8];
      end else begin
        werr_q.push_back(cyc + 1);
      end
      @(posedge clk); #1;
    end
    bus.w_we = 0; bus.w_last = 0; bus.w_req = 0;
  endtask

  // Both sides request in the same cycle; the side not served last wins.
  task automatic contend(input int rn, input arr8_t ra, input int wn,
                         input arr8_t wa, input arr8_t wd, input be8_t wb);
    int rw, ww;
    if (model_last_wr) begin rw = 1; ww = rn + 2; end
    else begin ww = 1; rw = wn + 2; end
    fork
      rd_burst(rn, ra, rw, 0, -1);
      wr_burst(wn, wa, wd, wb, ww);
    join
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, MEM_WORDS + 5)) * SLV_BYTEW + 32'($urandom_range(0, SLV_BYTEW-1));
  endfunction

  initial begin
    arr8_t a, a2, d;
    be8_t  b;
    int    rn, wn, mode;

    clear_inputs();
    do_reset();

    // fill memory so every later read has a known value
    for (int blk = 0; blk < MEM_WORDS / 4; blk++) begin
      for (int i = 0; i < 8; i++) begin
        a[i] = 32'((blk * 4 + i) * SLV_BYTEW); d[i] = $urandom; b[i] = '1;
      end
      wr_burst(4, a, d, b, 1);
    end

    for (int i = 0; i < 8; i++) a[i] = 32'(i * 4);
    rd_burst(4, a, 1, 0, -1);

    a[0] = 32'h10; d[0] = $urandom; b[0] = 4'b0101;
    wr_burst(1, a, d, b, 1);
    a[0] = 32'h10; a[1] = 32'h14;
    rd_burst(2, a, 1, 0, -1);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      a[i] = 32'(i * 8); a2[i] = 32'(i * 4 + 64); d[i] = $urandom; b[i] = 4'(i + 3);
    end
    contend(2, a, 3, a2, d, b);
    contend(3, a2, 1, a, d, b);

    a[0] = 32'(MEM_WORDS * SLV_BYTEW); a[1] = 32'h8; a[2] = 32'(MEM_WORDS * SLV_BYTEW + 4);
    rd_burst(3, a, 1, 0, -1);
    a[0] = 32'h20; a[1] = 32'(MEM_WORDS * SLV_BYTEW); a[2] = 32'h24;
    wr_burst(3, a, d, b, 1);

    chk("arb_err_clear", bus.arb_err, 0);
    a[0] = 32'h30; a[1] = 32'h34;
    rd_burst(2, a, 1, 1, -1);
    wr_burst(2, a, d, b, 1);
    chk("arb_err_sticky", bus.arb_err, 1);

    for (int i = 0; i < 8; i++) a[i] = 32'(i * 4 + 16);
    rd_burst(4, a, 1, 0, 1);
    repeat (MEM_WS + 4) @(posedge clk);
    #1;
    chk("arb_err_after_rst", bus.arb_err, 0);
    wr_burst(2, a, d, b, 1);

    for (int it = 0; it < 40; it++) begin
      rn = $urandom_range(1, 4);
      wn = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) begin
        a[i] = rand_addr(); a2[i] = rand_addr(); d[i] = $urandom;
        b[i] = SLV_BYTEW'($urandom_range(0, (1 << SLV_BYTEW) - 1));
      end
      mode = $urandom_range(0, 2);
      if (mode == 0) rd_burst(rn, a, 1, 0, -1);
      else if (mode == 1) wr_burst(wn, a2, d, b, 1);
      else contend(rn, a, wn, a2, d, b);
    end

    repeat (MEM_WS + 3) @(posedge clk);
    #1;
    chk("drain_rd_q", exp_q.size(), 0);
    chk("drain_werr_q", werr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
